// File: rtl/display_pixel_fetch.sv
// display_pixel_fetch
// Turns the timing generator's (sx, sy, de, hsync, vsync) stream into VGA pin
// values. Each screen position maps to a framebuffer address at
// 1/2^SCALE_SHIFT resolution. The RGB332 read data is expanded to 4:4:4.
// The syncs, de and the first-pixel flag are delayed so that they stay
// aligned with the colour of their own pixel. Total latency is RD_LAT + 2
// clock cycles.
//
// reset asserts asynchronously. Its source is expected to release it
// synchronously to clock_pix. No release synchroniser is placed here, so the
// first post-release input reaches the pins exactly RD_LAT + 2 cycles later.
module display_pixel_fetch #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int RD_LAT      = 2
) (
    input  logic              clock_pix,
    input  logic              reset,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic              de,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              test_mode,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [7:0]        fb_rd_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic              frame_start
);

    localparam int FB_W = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H = V_ACTIVE >> SCALE_SHIFT;

    // A framebuffer that does not fit in the address, or a zero-latency read
    // port, cannot be handled by this pipeline.
    if (RD_LAT < 1 || ADDR_W < $clog2(FB_W * FB_H)) begin : g_bad_params
        $error("display_pixel_fetch: RD_LAT must be >= 1 and ADDR_W must cover FB_W*FB_H");
    end

    // Side-band word that travels with each pixel:
    // [7] hsync, [6] vsync, [5] de, [4] first pixel of frame, [3] test mode,
    // [2:0] colour-bar index. The idle value has the syncs high (inactive)
    // and everything else low.
    localparam logic [7:0] SIDE_IDLE = 8'hC0;

    // ------------------------------------------------------------------
    // Stage A: mode latch, address generation, read strobe
    // ------------------------------------------------------------------
    logic              frame_origin;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_calc;
    logic [ADDR_W-1:0] fb_rd_addr_q, fb_rd_addr_d;
    logic              fb_rd_en_q, fb_rd_en_d;
    logic [7:0]        side_a_q, side_a_d;

    assign frame_origin = (sx == 10'd0) && (sy == 10'd0);

    // The row/column are the screen coordinates divided by the upscale
    // factor. The result wraps at ADDR_W bits, and the value is only used
    // while de is high.
    assign addr_calc = ADDR_W'(sy >> SCALE_SHIFT) * ADDR_W'(FB_W)
                     + ADDR_W'(sx >> SCALE_SHIFT);

    // Next-state for stage A. The mode changes only at the frame origin, and
    // the origin pixel already uses the new mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a value unassigned and infers a latch.
        mode_d       = mode_q;
        fb_rd_addr_d = fb_rd_addr_q;
        if (frame_origin) begin
            mode_d = test_mode;
        end
        if (de) begin
            fb_rd_addr_d = addr_calc;
        end
        fb_rd_en_d = de & ~mode_d;
        side_a_d   = {hsync, vsync, de, de & frame_origin, mode_d, sx[9:7]};
    end

    // Stage A registers: these drive the framebuffer read port directly.
    always_ff @(posedge clock_pix or posedge reset) begin
        if (reset) begin
            mode_q       <= 1'b0;
            fb_rd_en_q   <= 1'b0;
            fb_rd_addr_q <= '0;
            side_a_q     <= SIDE_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge inputs regardless of statement order.
            mode_q       <= mode_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_rd_addr_q <= fb_rd_addr_d;
            side_a_q     <= side_a_d;
        end
    end

    assign fb_rd_en   = fb_rd_en_q;
    assign fb_rd_addr = fb_rd_addr_q;

    // ------------------------------------------------------------------
    // Side-band delay matching the read latency
    // ------------------------------------------------------------------
    logic [7:0] side_q [RD_LAT];

    // Shift the side-band word RD_LAT more stages so that it meets
    // fb_rd_data for the same pixel.
    always_ff @(posedge clock_pix or posedge reset) begin
        if (reset) begin
            // NOTE: this delay line is reset element by element on purpose.
            // A flush must not let stale syncs or de reach the pins, so it
            // stays in flops and is not mapped to a RAM.
            for (int i = 0; i < RD_LAT; i++) begin
                side_q[i] <= SIDE_IDLE;
            end
        end else begin
            side_q[0] <= side_a_q;
            for (int i = 1; i < RD_LAT; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Colour generation and output registers
    // ------------------------------------------------------------------
    logic [7:0] side_al;
    logic       al_de;
    logic       al_mode;
    logic [2:0] al_bar;
    logic [3:0] r_d, g_d, b_d;

    assign side_al = side_q[RD_LAT-1];
    assign al_de   = side_al[5];
    assign al_mode = side_al[3];
    assign al_bar  = side_al[2:0];

    // Pick the pixel colour. Blanking forces black. Test mode shows
    // 128-pixel colour bars. Otherwise the RGB332 data is expanded by
    // repeating its top bits.
    always_comb begin
        r_d = 4'h0;
        g_d = 4'h0;
        b_d = 4'h0;
        if (al_de) begin
            if (al_mode) begin
                r_d = {4{al_bar[2]}};
                g_d = {4{al_bar[1]}};
                b_d = {4{al_bar[0]}};
            end else begin
                r_d = {fb_rd_data[7:5], fb_rd_data[7]};
                g_d = {fb_rd_data[4:2], fb_rd_data[4]};
                b_d = {fb_rd_data[1:0], fb_rd_data[1:0]};
            end
        end
    end

    logic [3:0] vga_r_q, vga_g_q, vga_b_q;
    logic       vga_hsync_q, vga_vsync_q, vga_de_q, frame_start_q;

    // Final register stage: every pin changes on the same edge.
    always_ff @(posedge clock_pix or posedge reset) begin
        if (reset) begin
            vga_r_q       <= 4'h0;
            vga_g_q       <= 4'h0;
            vga_b_q       <= 4'h0;
            vga_hsync_q   <= 1'b1;
            vga_vsync_q   <= 1'b1;
            vga_de_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vga_r_q       <= r_d;
            vga_g_q       <= g_d;
            vga_b_q       <= b_d;
            vga_hsync_q   <= side_al[7];
            vga_vsync_q   <= side_al[6];
            vga_de_q      <= al_de;
            frame_start_q <= side_al[4];
        end
    end

    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hsync   = vga_hsync_q;
    assign vga_vsync   = vga_vsync_q;
    assign vga_de      = vga_de_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_pixel_fetch.sv
// Bench for display_pixel_fetch.
// Three instances share one input stream: RD_LAT = 2 (the main one), 1 and 3.
// Each instance has its own fixed-latency memory model that returns
// addr[7:0] ^ mem_xor. Inputs are driven on the falling edge. Outputs are
// sampled on the falling edge, just before the next inputs are applied.
module tb_display_pixel_fetch;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        en;
        logic [14:0] addr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sx = '0;
    logic [9:0] sy = '0;
    logic       de = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic       test_mode = 1'b0;

    logic        en   [3];
    logic [14:0] addr [3];
    logic [3:0]  vr   [3];
    logic [3:0]  vg   [3];
    logic [3:0]  vb   [3];
    logic        vhs  [3];
    logic        vvs  [3];
    logic        vde  [3];
    logic        vfs  [3];
    logic [15:0] obs_pix [3];
    logic [15:0] obs_rd  [3];

    int   lat [3] = '{4, 3, 5};
    int   lines [11] = '{0, 1, 3, 4, 100, 101, 255, 479, 480, 490, 524};

    exp_t       hist [16];
    int         hx [16];
    int         hy [16];
    int         cyc = 0;
    logic       tb_mode = 1'b0;
    logic [14:0] exp_addr = '0;
    logic [7:0] mem_xor = 8'h00;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [14:0] a);
        return a[7:0] ^ mem_xor;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    function automatic logic [15:0] pack_pix(input exp_t e);
        return {e.hs, e.vs, e.de, e.fs, e.r, e.g, e.b};
    endfunction

    function automatic logic [15:0] pack_rd(input exp_t e);
        return {e.en, e.addr};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int RDL = (k == 0) ? 2 : ((k == 1) ? 1 : 3);
        logic [7:0] mp [RDL];

        display_pixel_fetch #(.RD_LAT(RDL)) u_dut (
            .clock_pix   (clk),
            .reset       (reset),
            .sx          (sx),
            .sy          (sy),
            .de          (de),
            .hsync       (hsync),
            .vsync       (vsync),
            .test_mode   (test_mode),
            .fb_rd_en    (en[k]),
            .fb_rd_addr  (addr[k]),
            .fb_rd_data  (mp[RDL-1]),
            .vga_r       (vr[k]),
            .vga_g       (vg[k]),
            .vga_b       (vb[k]),
            .vga_hsync   (vhs[k]),
            .vga_vsync   (vvs[k]),
            .vga_de      (vde[k]),
            .frame_start (vfs[k])
        );

        // Fixed-latency read port. Poison data appears when no read was issued.
        always @(posedge clk) begin
            mp[0] <= en[k] ? mem_val(addr[k]) : 8'h5A;
            for (int s = 1; s < RDL; s++) begin
                mp[s] <= mp[s-1];
            end
        end

        assign obs_pix[k] = {vhs[k], vvs[k], vde[k], vfs[k], vr[k], vg[k], vb[k]};
        assign obs_rd[k]  = {en[k], addr[k]};
    end

    // Drive one cycle of inputs (640x480@60 timing derived from x,y) and
    // record what the pins should show for it.
    task automatic apply(input int x, input int y, input logic tm, input logic rst_v);
        exp_t       e;
        logic       d;
        logic [7:0] dat;
        logic [2:0] bar;
        d = (x < 640) && (y < 480);
        sx = 10'(x);
        sy = 10'(y);
        de = d;
        hsync = !((x >= 656) && (x < 752));
        vsync = !((y >= 490) && (y < 492));
        test_mode = tm;
        reset = rst_v;
        if (rst_v) begin
            for (int i = 0; i < 16; i++) begin
                hist[i] = idle_exp();
                hx[i] = -1;
                hy[i] = -1;
            end
            tb_mode = 1'b0;
            exp_addr = '0;
            e = idle_exp();
        end else begin
            if (x == 0 && y == 0) tb_mode = tm;
            e = '0;
            e.hs = hsync;
            e.vs = vsync;
            e.de = d;
            e.fs = d && (x == 0) && (y == 0);
            e.en = d && !tb_mode;
            if (d) exp_addr = 15'((y >> 2) * 160 + (x >> 2));
            e.addr = exp_addr;
            if (d && tb_mode) begin
                bar = 3'(x >> 7);
                e.r = {4{bar[2]}};
                e.g = {4{bar[1]}};
                e.b = {4{bar[0]}};
            end else if (d) begin
                dat = mem_val(exp_addr);
                e.r = {dat[7:5], dat[7]};
                e.g = {dat[4:2], dat[4]};
                e.b = {dat[1:0], dat[1:0]};
            end
        end
        hist[cyc & 15] = e;
        hx[cyc & 15] = x;
        hy[cyc & 15] = y;
        cyc++;
    endtask

    task automatic test_reset();
        // Inputs toggle while reset is held: every pin must stay idle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_pix[k] !== 16'hC000) begin
                    n_fail++;
                    $display("FAIL reset_pins dut%0d i=%0d: got %h, want c000", k, i, obs_pix[k]);
                end
                n_checks++;
                if (obs_rd[k] !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL reset_rd dut%0d i=%0d: got %h, want 0000", k, i, obs_rd[k]);
                end
            end
            apply((i * 37) % 800, (i * 53) % 525, logic'(i & 1), 1'b1);
        end
        // Release mid-line. vga_de must rise exactly L cycles after the first input.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_pix[k][13] !== logic'(i >= lat[k])) begin
                    n_fail++;
                    $display("FAIL release_de dut%0d i=%0d: got %b, want %b", k, i, obs_pix[k][13], i >= lat[k]);
                end
                n_checks++;
                if (obs_pix[k] !== pack_pix(hist[(cyc - lat[k]) & 15])) begin
                    n_fail++;
                    $display("FAIL release_pix dut%0d i=%0d: got %h, want %h", k, i, obs_pix[k], pack_pix(hist[(cyc - lat[k]) & 15]));
                end
            end
            apply(300 + i, 4, 1'b0, 1'b0);
        end
    endtask

    task automatic test_single_pixel();
        // One lit pixel at (5,9). The memory is made to return E3 at address 321.
        mem_xor = 8'hA2;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 3) begin
                n_checks++;
                if (obs_rd[0] !== {1'b1, 15'd321}) begin
                    n_fail++;
                    $display("FAIL single_rd_issue: got %h, want %h", obs_rd[0], {1'b1, 15'd321});
                end
            end
            if (j == 4) begin
                n_checks++;
                if (obs_rd[0] !== {1'b0, 15'd321}) begin
                    n_fail++;
                    $display("FAIL single_addr_hold: got %h, want %h", obs_rd[0], {1'b0, 15'd321});
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (j == 2 + lat[k]) begin
                    n_checks++;
                    if (obs_pix[k][13:0] !== {1'b1, 1'b0, 12'hF0F}) begin
                        n_fail++;
                        $display("FAIL single_pixel dut%0d: got %h, want %h", k, obs_pix[k][13:0], {1'b1, 1'b0, 12'hF0F});
                    end
                end
                if (j == 1 + lat[k]) begin
                    n_checks++;
                    if (obs_pix[k][13] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL single_early dut%0d: got de=%b, want 0", k, obs_pix[k][13]);
                    end
                end
            end
            apply((j == 2) ? 5 : 645, 9, 1'b0, 1'b0);
        end
        mem_xor = 8'h00;
    endtask

    task automatic test_full_frame();
        int p;
        int q;
        for (int li = 0; li < 11; li++) begin
            for (int x = 0; x < 800; x++) begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (obs_pix[k] !== pack_pix(hist[(cyc - lat[k]) & 15])) begin
                        n_fail++;
                        $display("FAIL frame_pix dut%0d y=%0d x=%0d: got %h, want %h", k, hy[(cyc - lat[k]) & 15], hx[(cyc - lat[k]) & 15], obs_pix[k], pack_pix(hist[(cyc - lat[k]) & 15]));
                    end
                    n_checks++;
                    if (obs_rd[k] !== pack_rd(hist[(cyc - 1) & 15])) begin
                        n_fail++;
                        $display("FAIL frame_rd dut%0d cyc=%0d: got %h, want %h", k, cyc, obs_rd[k], pack_rd(hist[(cyc - 1) & 15]));
                    end
                end
                p = (cyc - 1) & 15;
                q = (cyc - 4) & 15;
                if ((hy[p] == 3 && hx[p] == 7) || (hy[p] == 1 && hx[p] == 4)) begin
                    n_checks++;
                    if (obs_rd[0] !== {1'b1, 15'd1}) begin
                        n_fail++;
                        $display("FAIL block_addr y=%0d x=%0d: got %h, want %h", hy[p], hx[p], obs_rd[0], {1'b1, 15'd1});
                    end
                end
                if (hy[p] == 101 && hx[p] == 322) begin
                    n_checks++;
                    if (obs_rd[0] !== {1'b1, 15'd4080}) begin
                        n_fail++;
                        $display("FAIL addr_4080: got %h, want %h", obs_rd[0], {1'b1, 15'd4080});
                    end
                end
                if (hy[p] == 479 && hx[p] == 639) begin
                    n_checks++;
                    if (obs_rd[0] !== {1'b1, 15'd19199}) begin
                        n_fail++;
                        $display("FAIL addr_last: got %h, want %h", obs_rd[0], {1'b1, 15'd19199});
                    end
                end
                if (hy[q] == 479 && hx[q] == 639) begin
                    n_checks++;
                    if (obs_pix[0][11:0] !== 12'hFFF) begin
                        n_fail++;
                        $display("FAIL rgb_last: got %h, want fff", obs_pix[0][11:0]);
                    end
                end
                if (hy[q] == 1 && hx[q] == 4) begin
                    n_checks++;
                    if (obs_pix[0][11:0] !== 12'h005) begin
                        n_fail++;
                        $display("FAIL rgb_addr1: got %h, want 005", obs_pix[0][11:0]);
                    end
                end
                apply(x, lines[li], 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_frame_start();
        int   pulses;
        int   rises;
        logic prev_de;
        logic rise;
        for (int f = 0; f < 2; f++) begin
            pulses = 0;
            rises = 0;
            prev_de = 1'b0;
            for (int li = 0; li < 11; li++) begin
                for (int x = 0; x < 800; x++) begin
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        n_checks++;
                        if (obs_pix[k] !== pack_pix(hist[(cyc - lat[k]) & 15])) begin
                            n_fail++;
                            $display("FAIL fs_pix dut%0d cyc=%0d: got %h, want %h", k, cyc, obs_pix[k], pack_pix(hist[(cyc - lat[k]) & 15]));
                        end
                    end
                    rise = obs_pix[0][13] && !prev_de;
                    if (obs_pix[0][12]) begin
                        pulses++;
                        n_checks++;
                        if (!(rise && rises == 0)) begin
                            n_fail++;
                            $display("FAIL fs_align frame=%0d: got rise=%b prior_rises=%0d, want rise=1 prior_rises=0", f, rise, rises);
                        end
                    end
                    if (rise) rises++;
                    prev_de = obs_pix[0][13];
                    apply(x, lines[li], 1'b0, 1'b0);
                end
            end
            n_checks++;
            if (pulses !== 1) begin
                n_fail++;
                $display("FAIL fs_count frame=%0d: got %0d pulses, want 1", f, pulses);
            end
        end
    endtask

    task automatic test_mode_switch();
        int   p;
        int   q;
        logic tm;
        logic [11:0] want;
        for (int f = 0; f < 2; f++) begin
            for (int li = 0; li < 11; li++) begin
                tm = (f == 1) || (lines[li] >= 100);
                for (int x = 0; x < 800; x++) begin
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        n_checks++;
                        if (obs_pix[k] !== pack_pix(hist[(cyc - lat[k]) & 15])) begin
                            n_fail++;
                            $display("FAIL mode_pix dut%0d cyc=%0d: got %h, want %h", k, cyc, obs_pix[k], pack_pix(hist[(cyc - lat[k]) & 15]));
                        end
                        n_checks++;
                        if (obs_rd[k] !== pack_rd(hist[(cyc - 1) & 15])) begin
                            n_fail++;
                            $display("FAIL mode_rd dut%0d cyc=%0d: got %h, want %h", k, cyc, obs_rd[k], pack_rd(hist[(cyc - 1) & 15]));
                        end
                    end
                    p = (cyc - 1) & 15;
                    q = (cyc - 4) & 15;
                    if (f == 0 && hy[p] == 255 && hx[p] == 10) begin
                        n_checks++;
                        if (obs_rd[0][15] !== 1'b1) begin
                            n_fail++;
                            $display("FAIL mode_midframe_rd: got %b, want 1", obs_rd[0][15]);
                        end
                    end
                    if (f == 1) begin
                        n_checks++;
                        if (obs_rd[0][15] !== 1'b0) begin
                            n_fail++;
                            $display("FAIL bars_no_read y=%0d x=%0d: got %b, want 0", hy[p], hx[p], obs_rd[0][15]);
                        end
                        if (hy[q] == 100 && (hx[q] == 0 || hx[q] == 200 || hx[q] == 300 || hx[q] == 400 || hx[q] == 600)) begin
                            case (hx[q])
                                0:       want = 12'h000;
                                200:     want = 12'h00F;
                                300:     want = 12'h0F0;
                                400:     want = 12'h0FF;
                                default: want = 12'hF00;
                            endcase
                            n_checks++;
                            if (obs_pix[0][11:0] !== want) begin
                                n_fail++;
                                $display("FAIL bars x=%0d: got %h, want %h", hx[q], obs_pix[0][11:0], want);
                            end
                        end
                    end
                    apply(x, lines[li], tm, 1'b0);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            hist[i] = idle_exp();
            hx[i] = -1;
            hy[i] = -1;
        end
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_frame_start();
        test_mode_switch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
